// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Optional subtraction is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN.
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle for the nibble-serial adder controller.
// The sub port exists only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// One 4-bit carry-lookahead adder slice, shared across all nibbles.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c0,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  assign g = x & y;
  assign p = x ^ y;

  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s    = p ^ {c[3:1], c0};
  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one shared 4-bit CLA slice processes a WIDTH-bit add over WIDTH/4 cycles.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub input (a - b).
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int NSLICE = nslice(WIDTH);
  localparam int CNT_W  = $clog2(NSLICE);
  localparam int MSB    = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [3:0]       x_s;
  logic [3:0]       y_s;
  logic [3:0]       s_s;
  logic             c_s;

  // Operand conditioning at capture time: subtraction is a + ~b + 1.
  always_comb begin
    b_eff_s = bus.b;
    c0_s    = bus.cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_eff_s = ~bus.b;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = bus.b;
      c0_s    = bus.cin;
    end
`endif
  end

  // Select the current nibble of the captured operands.
  always_comb begin
    x_s = a_r[cnt_r*SLICE_W +: SLICE_W];
    y_s = b_r[cnt_r*SLICE_W +: SLICE_W];
  end

  cla4_slice u_slice (
    .x    (x_s),
    .y    (y_s),
    .c0   (carry_r),
    .s    (s_s),
    .cout (c_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST_SLICE) state_s = DONE;
        else                     state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, one nibble per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= b_eff_s;
            carry_r <= c0_s;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          sum_r[cnt_r*SLICE_W +: SLICE_W] <= s_s;
          carry_r <= c_s;
          cnt_r   <= cnt_r + 1'b1;
          // Flags come from the top slice, so they only land on the last step.
          if (cnt_r == LAST_SLICE) begin
            cout_r <= c_s;
            ovf_r  <= (a_r[MSB] == b_r[MSB]) && (s_s[3] != a_r[MSB]);
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16 and WIDTH=8 instances).
// Subtraction vectors run only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_ctrl_if #(.WIDTH(8))  bus8 ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold start across one edge (edge 0 of the op).
  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus16.a = a;
    bus16.b = b;
    bus16.cin = cin;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
  endtask

  task automatic wait_done16(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = bus16.done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    bus16.sub = 1'b0;
    bus8.sub = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if ({bus16.busy, bus16.done, bus16.sum, bus16.cout, bus16.ovf} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b exp all zero",
               bus16.busy, bus16.done, bus16.sum, bus16.cout, bus16.ovf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    launch16(16'h1234, 16'h4321, 1'b0);
    checks++;
    if (bus16.busy !== 1'b1 || bus16.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_edge0 got busy=%b done=%b exp busy=1 done=0", bus16.busy, bus16.done);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (bus16.done !== 1'b0 || bus16.busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_run_edge%0d got busy=%b done=%b exp busy=1 done=0", e, bus16.busy, bus16.done);
      end
    end
    tick();
    checks++;
    if (bus16.done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_edge4 got done=%b exp 1", bus16.done);
    end
    checks++;
    if (bus16.sum !== 16'h5555 || bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got sum=%h cout=%b ovf=%b exp sum=5555 cout=0 ovf=0",
               bus16.sum, bus16.cout, bus16.ovf);
    end
    tick();
    checks++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_edge5 got busy=%b done=%b exp busy=0 done=0", bus16.busy, bus16.done);
    end
  endtask

  task automatic test_carry_ovf();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vc [4];
    logic [15:0] es [4];
    logic        eco [4];
    logic        eov [4];
    bit seen;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; es[0] = 16'h0000; eco[0] = 1'b1; eov[0] = 1'b0;
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0; es[1] = 16'h8000; eco[1] = 1'b0; eov[1] = 1'b1;
    va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b0; es[2] = 16'h0000; eco[2] = 1'b1; eov[2] = 1'b1;
    va[3] = 16'h00FF; vb[3] = 16'h0000; vc[3] = 1'b1; es[3] = 16'h0100; eco[3] = 1'b0; eov[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      launch16(va[k], vb[k], vc[k]);
      wait_done16(seen);
      checks++;
      if (seen !== 1'b1) begin
        failures++;
        $display("FAIL carry_timeout vec=%0d got done=%b exp 1", k, seen);
      end
      checks++;
      if (bus16.sum !== es[k] || bus16.cout !== eco[k] || bus16.ovf !== eov[k]) begin
        failures++;
        $display("FAIL carry_result vec=%0d got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                 k, bus16.sum, bus16.cout, bus16.ovf, es[k], eco[k], eov[k]);
      end
      tick();
    end
    // Results must hold in IDLE.
    tick();
    checks++;
    if (bus16.sum !== 16'h0100 || bus16.busy !== 1'b0) begin
      failures++;
      $display("FAIL carry_hold got sum=%h busy=%b exp sum=0100 busy=0", bus16.sum, bus16.busy);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    int pulse_edge;
    launch16(16'h1234, 16'h1111, 1'b0);
    tick();
    bus16.a = 16'h0001;
    bus16.b = 16'h0001;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    pulses = 0;
    pulse_edge = -1;
    for (int e = 3; e <= 9; e++) begin
      tick();
      if (bus16.done === 1'b1) begin
        pulses++;
        pulse_edge = e;
      end
    end
    checks++;
    if (pulses !== 1 || pulse_edge !== 4) begin
      failures++;
      $display("FAIL ignore_pulses got count=%0d edge=%0d exp count=1 edge=4", pulses, pulse_edge);
    end
    checks++;
    if (bus16.sum !== 16'h2345 || bus16.busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result got sum=%h busy=%b exp sum=2345 busy=0", bus16.sum, bus16.busy);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    launch16(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.sum !== 16'h0000) begin
      failures++;
      $display("FAIL abort_outputs got busy=%b done=%b sum=%h exp busy=0 done=0 sum=0000",
               bus16.busy, bus16.done, bus16.sum);
    end
    tick();
    rst = 1'b0;
    bus16.a = 16'h0003;
    bus16.b = 16'h0004;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    checks++;
    if (bus16.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_first_accept got busy=%b exp 1", bus16.busy);
    end
    wait_done16(seen);
    checks++;
    if (seen !== 1'b1 || bus16.sum !== 16'h0007) begin
      failures++;
      $display("FAIL abort_next_op got done=%b sum=%h exp done=1 sum=0007", seen, bus16.sum);
    end
    tick();
  endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    bit seen;
    bus16.sub = 1'b1;
    launch16(16'h0005, 16'h0007, 1'b0);
    wait_done16(seen);
    checks++;
    if (seen !== 1'b1 || bus16.sum !== 16'hFFFE || bus16.cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow got done=%b sum=%h cout=%b exp done=1 sum=fffe cout=0",
               seen, bus16.sum, bus16.cout);
    end
    tick();
    launch16(16'h0007, 16'h0005, 1'b0);
    wait_done16(seen);
    checks++;
    if (seen !== 1'b1 || bus16.sum !== 16'h0002 || bus16.cout !== 1'b1) begin
      failures++;
      $display("FAIL sub_noborrow got done=%b sum=%h cout=%b exp done=1 sum=0002 cout=1",
               seen, bus16.sum, bus16.cout);
    end
    bus16.sub = 1'b0;
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] es [3];
    logic       eco [3];
    logic       eov [3];
    logic       exp_done;
    va[0] = 8'h12; vb[0] = 8'h34; es[0] = 8'h46; eco[0] = 1'b0; eov[0] = 1'b0;
    va[1] = 8'hF0; vb[1] = 8'h20; es[1] = 8'h10; eco[1] = 1'b1; eov[1] = 1'b0;
    va[2] = 8'h7F; vb[2] = 8'h01; es[2] = 8'h80; eco[2] = 1'b0; eov[2] = 1'b1;
    bus8.a = va[0];
    bus8.b = vb[0];
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_done = ((e % 4) == 2);
      checks++;
      if (bus8.done !== exp_done) begin
        failures++;
        $display("FAIL b2b_done edge=%0d got %b exp %b", e, bus8.done, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (bus8.sum !== es[e/4] || bus8.cout !== eco[e/4] || bus8.ovf !== eov[e/4]) begin
          failures++;
          $display("FAIL b2b_result op=%0d got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                   e / 4, bus8.sum, bus8.cout, bus8.ovf, es[e/4], eco[e/4], eov[e/4]);
        end
      end
      if ((e % 4) == 1 && (e / 4 + 1) < 3) begin
        bus8.a = va[e/4 + 1];
        bus8.b = vb[e/4 + 1];
      end
    end
    bus8.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus8.busy !== 1'b0 || bus8.sum !== 8'h80) begin
      failures++;
      $display("FAIL b2b_drain got busy=%b sum=%h exp busy=0 sum=80", bus8.busy, bus8.sum);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_carry_ovf();
    test_ignore_start();
    test_reset_abort();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant: NSLICE = WIDTH/4, the number of 4-bit slices; the slice counter is clog2(NSLICE) bits wide.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 start  input  1  request a new addition; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-007 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-008 cin  input  1  carry-in to slice 0; captured on the accepted start edge.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse; high only in DONE.
REQ-011 sum  output  WIDTH  result register.
REQ-012 cout  output  1  carry-out of the top slice.
REQ-013 ovf  output  1  signed overflow: (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]), using the captured operands.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with transitions:
- IDLE->RUN on start=1.
- RUN->DONE when the slice counter equals NSLICE-1.
- DONE->IDLE unconditionally.
REQ-015 On an accepted start, the block SHALL capture a, b and cin into internal registers, clear the slice counter, and leave sum unchanged.
REQ-016 Each RUN cycle, the block SHALL feed slice i (bits 4i+3:4i) of the captured A and B, plus the carry register, to one shared 4-bit carry-lookahead slice.
- It SHALL write the 4-bit result to sum[4i+3:4i].
- It SHALL load the slice carry-out into the carry register.
- It SHALL increment i.
REQ-017 Latency: with start accepted at edge k, slices complete at edges k+1..k+NSLICE, done is high during the cycle after edge k+NSLICE, and busy falls at edge k+NSLICE+1.
REQ-018 The block SHALL ignore start while busy=1; captured operands SHALL be unaffected by input changes while busy.
REQ-019 start held continuously SHALL launch back-to-back operations, one every NSLICE+2 cycles.
REQ-020 sum, cout and ovf SHALL update only during RUN and SHALL hold their values from DONE until the next accepted start completes the corresponding slices.
- cout and ovf SHALL become valid in DONE.
- Partial sums during RUN are don't-care to consumers.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of bit WIDTH-1 presented on cout.

Reset
REQ-022 Reset values: state=IDLE, slice counter=0, carry register=0, captured operands=0, sum=0, cout=0, ovf=0, busy=0, done=0.
REQ-023 Reset asserted mid-RUN or in DONE SHALL abort immediately with no done pulse; after release the block SHALL be in IDLE and accept start on the first edge.

Configuration
REQ-024 Macro NIBBLE_SERIAL_ADDER_SUB_EN controls subtraction support.
- When defined, the block SHALL add input port sub (1 bit, captured with start).
- With sub=1, b_eff = ~b and the slice-0 carry-in SHALL be 1 (cin ignored), giving a-b.
- With sub=1, cout=1 SHALL mean no borrow.
REQ-025 When NIBBLE_SERIAL_ADDER_SUB_EN is undefined, there SHALL be no sub port and b_eff = b.

Structure
REQ-026 A shared package SHALL hold:
- the FSM state enumeration (IDLE/RUN/DONE);
- the slice width constant (4);
- a function computing NSLICE from WIDTH.
REQ-027 The 4-bit carry-lookahead datapath SHALL be a single sub-module instance, cla4_slice, with inputs x[3:0], y[3:0], c0 and outputs s[3:0], cout.
- It SHALL be instantiated exactly once.
- The controller SHALL contain no other adders apart from the slice counter increment.

Verification (WIDTH=16 unless noted)
REQ-028 a=0x1234, b=0x4321, cin=0, start at edge 0 -> done high in cycle after edge 4, sum=0x5555, cout=0, ovf=0, busy low after edge 5.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-030 Start pulsed again at edge 2 with a=0x0001, b=0x0001 during a busy operation -> ignored; first result unchanged; exactly one done pulse.
REQ-031 rst asserted between edges 2 and 3 of a 0x1111+0x2222 operation -> busy=0, done=0, sum=0 immediately; next start with 0x0003+0x0004 gives 0x0007.
REQ-032 With NIBBLE_SERIAL_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-033 WIDTH=8, start held high for 12 cycles -> done pulses at cycles 3 and 7 after the first accept, with no lost or duplicated operations.
